// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM generator: shared prescaler and period counter, commands double-buffered to period boundaries.
// Optional duty ramping is compiled in when PWM_GEN_MC_RAMP_EN is defined.
module pwm_gen_mc #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 10,
    parameter int CNT_W     = 16,
    parameter int PRESCALE  = 64,
    parameter int PERIOD    = 530,
    parameter int OFFSET    = 250,
    parameter int DEADZONE  = 12,
    parameter int RAMP_STEP = 4
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic [CHANNELS*WIDTH-1:0] PWMinput,
    input  logic [CHANNELS-1:0]       enable,
    input  logic                      load,
    output logic                      load_ack,
    output logic                      period_start,
    output logic [CHANNELS-1:0]       PWMout
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]           presc_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic                      tick;
    logic                      boundary;
    logic                      pend_flag_reg;
    logic [CHANNELS*WIDTH-1:0] pending_reg;
    logic [CHANNELS*WIDTH-1:0] target_reg;
    logic [CHANNELS*WIDTH-1:0] target_next;
    logic [WIDTH-1:0]          duty [CHANNELS];
    logic [CNT_W:0]            eff  [CHANNELS];
    logic [CHANNELS-1:0]       pwm_next;

    assign tick        = (presc_reg == PS_W'(PRESCALE - 1));
    assign boundary    = tick && (cnt_reg == CNT_W'(PERIOD - 1));
    assign target_next = (boundary && pend_flag_reg) ? pending_reg : target_reg;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick)
                cnt_reg <= (cnt_reg == CNT_W'(PERIOD - 1)) ? '0 : cnt_reg + 1'b1;
        end
    end

    // A load coinciding with a boundary refills pending after the old pending value is consumed.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_reg   <= '0;
            pend_flag_reg <= 1'b0;
            target_reg    <= '0;
        end else begin
            target_reg <= target_next;
            if (load) begin
                pending_reg   <= PWMinput;
                pend_flag_reg <= 1'b1;
            end else if (boundary) begin
                pend_flag_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            load_ack     <= 1'b0;
            period_start <= 1'b0;
            PWMout       <= '0;
        end else begin
            load_ack     <= boundary && pend_flag_reg;
            period_start <= boundary;
            PWMout       <= pwm_next;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
`ifdef PWM_GEN_MC_RAMP_EN
            logic [WIDTH-1:0] act_reg;
            logic [WIDTH-1:0] tgt;

            assign tgt = target_next[gi*WIDTH +: WIDTH];

            // Step toward the target that becomes current at this boundary.
            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    act_reg <= '0;
                end else if (boundary) begin
                    if (tgt > act_reg)
                        act_reg <= ({1'b0, tgt - act_reg} > (WIDTH+1)'(RAMP_STEP)) ?
                                   act_reg + WIDTH'(RAMP_STEP) : tgt;
                    else if (tgt < act_reg)
                        act_reg <= ({1'b0, act_reg - tgt} > (WIDTH+1)'(RAMP_STEP)) ?
                                   act_reg - WIDTH'(RAMP_STEP) : tgt;
                end
            end

            assign duty[gi] = act_reg;
`else
            assign duty[gi] = target_reg[gi*WIDTH +: WIDTH];
`endif
            // One extra bit keeps duty+OFFSET from wrapping; anything >= PERIOD is solid high.
            assign eff[gi] = (32'(duty[gi]) <= DEADZONE) ? '0 :
                             (CNT_W+1)'(duty[gi]) + (CNT_W+1)'(OFFSET);
            assign pwm_next[gi] = enable[gi] && ({1'b0, cnt_reg} < eff[gi]);
        end
    endgenerate

endmodule

// File: tb/tb_pwm_gen_mc.sv
// Self-checking bench for pwm_gen_mc: randomized commands checked against a period-arithmetic reference model.
module tb_pwm_gen_mc;

    localparam int CH  = 4;
    localparam int W   = 6;
    localparam int CW  = 8;
    localparam int PS  = 3;
    localparam int PER = 50;
    localparam int OFF = 20;
    localparam int DZ  = 5;
    localparam int RS  = 4;
    localparam int PP  = PS * PER;

    logic              CLOCK_50 = 1'b0;
    logic              RESET_N  = 1'b0;
    logic [CH*W-1:0]   PWMinput = '0;
    logic [CH-1:0]     enable   = '0;
    logic              load     = 1'b0;
    logic              load_ack;
    logic              period_start;
    logic [CH-1:0]     PWMout;

    int checks = 0;
    int errors = 0;

    pwm_gen_mc #(
        .CHANNELS(CH), .WIDTH(W), .CNT_W(CW), .PRESCALE(PS), .PERIOD(PER),
        .OFFSET(OFF), .DEADZONE(DZ), .RAMP_STEP(RS)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N(RESET_N),
        .PWMinput(PWMinput),
        .enable(enable),
        .load(load),
        .load_ack(load_ack),
        .period_start(period_start),
        .PWMout(PWMout)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: clock index m since reset; counter = (m / PS) % PER, boundary on last clock of a period.
    int            m          = 0;
    logic          m_pend     = 1'b0;
    logic [CH*W-1:0] m_pend_val = '0;
    logic [CH*W-1:0] m_act    = '0;
    logic [CH-1:0] exp_pwm    = '0;
    logic          exp_ack    = 1'b0;
    logic          exp_ps     = 1'b0;
    int            phase_w;

    assign phase_w = m % PP;

    function automatic int eff_of(input int d);
        return (d <= DZ) ? 0 : d + OFF;
    endfunction

    function automatic int high_clocks(input int d);
        int e;
        e = eff_of(d);
        return ((e >= PER) ? PER : e) * PS;
    endfunction

    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            m          <= 0;
            m_pend     <= 1'b0;
            m_pend_val <= '0;
            m_act      <= '0;
            exp_pwm    <= '0;
            exp_ack    <= 1'b0;
            exp_ps     <= 1'b0;
        end else begin
            for (int k = 0; k < CH; k++)
                exp_pwm[k] <= enable[k] && ((phase_w / PS) < eff_of(int'(m_act[k*W +: W])));
            exp_ps  <= (phase_w == PP - 1);
            exp_ack <= (phase_w == PP - 1) && m_pend;
            if (phase_w == PP - 1 && m_pend)
                m_act <= m_pend_val;
            if (load) begin
                m_pend_val <= PWMinput;
                m_pend     <= 1'b1;
            end else if (phase_w == PP - 1) begin
                m_pend <= 1'b0;
            end
            m <= m + 1;
        end
    end

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if (PWMout !== '0) begin
            errors++;
            $display("FAIL reset_pwmout: got %b want 0", PWMout);
        end
        checks++;
        if (load_ack !== 1'b0 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: load_ack=%b period_start=%b want 0/0", load_ack, period_start);
        end
        RESET_N = 1'b1;
        $display("test_reset: done");
    endtask

    // Load a channel-0 command, wait for it to take effect, then measure one full period of high time.
    task automatic test_duty(input logic [W-1:0] cmd);
        int acks, high, waited;
        PWMinput        = (CH*W)'($urandom);
        PWMinput[W-1:0] = cmd;
        enable          = '1;
        load            = 1'b1;
        acks            = 0;
        waited          = 0;
        do begin
            @(negedge CLOCK_50);
            load = 1'b0;
            waited++;
            checks++;
            if ({PWMout, load_ack, period_start} !== {exp_pwm, exp_ack, exp_ps}) begin
                errors++;
                $display("FAIL duty_wait cmd=%0d m=%0d: got pwm=%b ack=%b ps=%b want %b %b %b",
                         cmd, m, PWMout, load_ack, period_start, exp_pwm, exp_ack, exp_ps);
            end
            if (load_ack) acks++;
        end while (!load_ack && waited < 2*PP + 2);
        checks++;
        if (!load_ack) begin
            errors++;
            $display("FAIL duty_ack_timeout cmd=%0d: got no load_ack within %0d clocks, want one", cmd, waited);
        end
        @(negedge CLOCK_50);
        high = 0;
        repeat (PP) begin
            @(negedge CLOCK_50);
            checks++;
            if ({PWMout, load_ack, period_start} !== {exp_pwm, exp_ack, exp_ps}) begin
                errors++;
                $display("FAIL duty_window cmd=%0d m=%0d: got pwm=%b ack=%b ps=%b want %b %b %b",
                         cmd, m, PWMout, load_ack, period_start, exp_pwm, exp_ack, exp_ps);
            end
            if (PWMout[0]) high++;
            if (load_ack) acks++;
        end
        checks++;
        if (high !== high_clocks(int'(cmd))) begin
            errors++;
            $display("FAIL duty_high cmd=%0d: got %0d high clocks want %0d", cmd, high, high_clocks(int'(cmd)));
        end
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL duty_ack_count cmd=%0d: got %0d pulses want 1", cmd, acks);
        end
        $display("test_duty: cmd=%0d high=%0d expected=%0d acks=%0d", cmd, high, high_clocks(int'(cmd)), acks);
    endtask

    task automatic test_reset_mid();
        int waited;
        enable = '1;
        waited = 0;
        while (phase_w != 5 && waited < PP + 2) begin
            @(negedge CLOCK_50);
            waited++;
        end
        PWMinput        = (CH*W)'($urandom);
        PWMinput[W-1:0] = 6'd30;
        load            = 1'b1;
        @(negedge CLOCK_50);
        load = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if ({PWMout, load_ack, period_start} !== '0) begin
            errors++;
            $display("FAIL reset_mid_immediate: got pwm=%b ack=%b ps=%b want all 0", PWMout, load_ack, period_start);
        end
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        waited  = 0;
        do begin
            @(negedge CLOCK_50);
            waited++;
            checks++;
            if ({PWMout, load_ack, period_start} !== {exp_pwm, exp_ack, exp_ps}) begin
                errors++;
                $display("FAIL reset_mid_run m=%0d: got pwm=%b ack=%b ps=%b want %b %b %b",
                         m, PWMout, load_ack, period_start, exp_pwm, exp_ack, exp_ps);
            end
        end while (!period_start && waited < PP + 5);
        checks++;
        if (waited !== PP) begin
            errors++;
            $display("FAIL reset_mid_first_period: got period_start after %0d clocks want %0d", waited, PP);
        end
        checks++;
        if (load_ack !== 1'b0 || PWMout !== '0) begin
            errors++;
            $display("FAIL reset_mid_discard: got ack=%b pwm=%b want 0 and 0", load_ack, PWMout);
        end
        $display("test_reset_mid: first period_start after %0d clocks", waited);
    endtask

    task automatic test_last_wins();
        int waited, high, acks;
        enable = '1;
        waited = 0;
        while (phase_w != 2 && waited < PP + 2) begin
            @(negedge CLOCK_50);
            waited++;
        end
        PWMinput[W-1:0] = 6'd20;
        load = 1'b1;
        @(negedge CLOCK_50);
        load = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        PWMinput[W-1:0] = 6'd8;
        load = 1'b1;
        @(negedge CLOCK_50);
        load   = 1'b0;
        waited = 0;
        acks   = 0;
        do begin
            @(negedge CLOCK_50);
            waited++;
            checks++;
            if ({PWMout, load_ack, period_start} !== {exp_pwm, exp_ack, exp_ps}) begin
                errors++;
                $display("FAIL last_wins_wait m=%0d: got pwm=%b ack=%b ps=%b want %b %b %b",
                         m, PWMout, load_ack, period_start, exp_pwm, exp_ack, exp_ps);
            end
        end while (!load_ack && waited < 2*PP);
        @(negedge CLOCK_50);
        high = 0;
        repeat (PP) begin
            @(negedge CLOCK_50);
            if (PWMout[0]) high++;
            if (load_ack) acks++;
        end
        checks++;
        if (high !== high_clocks(8)) begin
            errors++;
            $display("FAIL last_wins_high: got %0d high clocks want %0d", high, high_clocks(8));
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL last_wins_extra_ack: got %0d extra pulses want 0", acks);
        end
        $display("test_last_wins: loads 20 then 8, high=%0d", high);
    endtask

    task automatic test_load_at_boundary();
        int waited, high;
        enable = '1;
        waited = 0;
        while (phase_w != PP - 1 && waited < PP + 2) begin
            @(negedge CLOCK_50);
            waited++;
        end
        PWMinput[W-1:0] = 6'd15;
        load = 1'b1;
        @(negedge CLOCK_50);
        load = 1'b0;
        checks++;
        if (period_start !== 1'b1 || load_ack !== 1'b0) begin
            errors++;
            $display("FAIL boundary_load_same: got ps=%b ack=%b want 1 and 0", period_start, load_ack);
        end
        waited = 0;
        do begin
            @(negedge CLOCK_50);
            waited++;
            checks++;
            if ({PWMout, load_ack, period_start} !== {exp_pwm, exp_ack, exp_ps}) begin
                errors++;
                $display("FAIL boundary_load_wait m=%0d: got pwm=%b ack=%b ps=%b want %b %b %b",
                         m, PWMout, load_ack, period_start, exp_pwm, exp_ack, exp_ps);
            end
        end while (!load_ack && waited < 2*PP);
        checks++;
        if (waited !== PP) begin
            errors++;
            $display("FAIL boundary_load_delay: got load_ack after %0d clocks want %0d", waited, PP);
        end
        @(negedge CLOCK_50);
        high = 0;
        repeat (PP) begin
            @(negedge CLOCK_50);
            if (PWMout[0]) high++;
        end
        checks++;
        if (high !== high_clocks(15)) begin
            errors++;
            $display("FAIL boundary_load_high: got %0d high clocks want %0d", high, high_clocks(15));
        end
        $display("test_load_at_boundary: ack after %0d clocks, high=%0d", waited, high);
    endtask

    task automatic test_random_traffic();
        int loads;
        loads = 0;
        for (int i = 0; i < 6*PP; i++) begin
            enable = CH'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                PWMinput = (CH*W)'($urandom);
                load     = 1'b1;
                loads++;
            end else begin
                load = 1'b0;
            end
            @(negedge CLOCK_50);
            checks++;
            if ({PWMout, load_ack, period_start} !== {exp_pwm, exp_ack, exp_ps}) begin
                errors++;
                $display("FAIL random m=%0d: got pwm=%b ack=%b ps=%b want %b %b %b",
                         m, PWMout, load_ack, period_start, exp_pwm, exp_ack, exp_ps);
            end
        end
        load = 1'b0;
        $display("test_random_traffic: %0d clocks, %0d loads", 6*PP, loads);
    endtask

    initial begin
        test_reset();
        test_duty(6'd10);
        test_duty(6'd5);
        test_duty(6'd6);
        test_duty(6'd63);
        test_reset_mid();
        test_last_wins();
        test_load_at_boundary();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
